sram_request_arbiter: RTL and testbench

SRAM_REQUEST_ARBITER -- requirements
Module: sram_request_arbiter

---
 rtl/sram_request_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_sram_request_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_request_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one SRAM-like bus, tracking
// accepted-but-unanswered transactions in an in-order ID queue to route responses back.
module sram_request_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CntW    = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned StarveW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic {
        OwnInst = 1'b0,
        OwnData = 1'b1
    } owner_e;

    typedef enum logic {
        StIdle   = 1'b0,
        StLocked = 1'b1
    } state_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [StarveW-1:0]  starve_q, starve_d;
    logic [CntW-1:0]     count_q, count_d;
    owner_e              id_q [MAX_OUTSTANDING];
    owner_e              id_d [MAX_OUTSTANDING];

    owner_e              grant;
    logic                grant_req;
    logic                full;
    logic                starved;
    logic                req_out;
    logic                accept;
    logic                pop;
    logic [CntW-1:0]     wr_idx;

    // Fullness uses the registered count only, so a same-cycle pop cannot open a slot.
    assign full    = (count_q == CntW'(MAX_OUTSTANDING));
    assign starved = (starve_q >= StarveW'(STARVE_LIMIT));

    always_comb begin
        grant = OwnData;
        if (state_q == StLocked) begin
            grant = owner_q;
        end else if (data_req && inst_req) begin
            grant = starved ? OwnInst : OwnData;
        end else if (inst_req) begin
            grant = OwnInst;
        end else begin
            grant = OwnData;
        end
        grant_req = (grant == OwnData) ? data_req : inst_req;
    end

    assign req_out = !reset && !full && grant_req;
    assign accept  = req_out && mem_addr_ok;
    assign pop     = !reset && mem_data_ok && (count_q != '0);

    always_comb begin
        mem_req   = req_out;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (req_out) begin
            if (grant == OwnData) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_wr    = inst_wr;
                mem_size  = inst_size;
                mem_addr  = inst_addr;
                mem_wdata = inst_wdata;
            end
        end
    end

    assign inst_addr_ok = accept && (grant == OwnInst);
    assign data_addr_ok = accept && (grant == OwnData);
    assign inst_data_ok = pop && (id_q[0] == OwnInst);
    assign data_data_ok = pop && (id_q[0] == OwnData);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    // Lock FSM: a presented-but-unaccepted request pins the owner until the memory takes it.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            StIdle: begin
                if (req_out && !mem_addr_ok) begin
                    state_d = StLocked;
                    owner_d = grant;
                end
            end
            StLocked: begin
                if (accept || !grant_req) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!inst_req || (accept && grant == OwnInst)) begin
            starve_d = '0;
        end else if (accept && grant == OwnData && !starved) begin
            starve_d = starve_q + StarveW'(1);
        end
    end

    // In-order ID queue kept as a shift register; head is always entry 0.
    always_comb begin
        id_d    = id_q;
        count_d = count_q;
        wr_idx  = count_q - CntW'(pop);
        if (pop) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING) - 1; i++) begin
                id_d[i] = id_q[i+1];
            end
            id_d[MAX_OUTSTANDING-1] = OwnInst;
        end
        if (accept) begin
            id_d[wr_idx] = grant;
        end
        if (accept && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !accept) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            owner_q  <= OwnInst;
            starve_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                id_q[i] <= OwnInst;
            end
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            count_q  <= count_d;
            id_q     <= id_d;
        end
    end

endmodule

// File: tb/tb_sram_request_arbiter.sv
// Scoreboard bench: stimulus pushes expected accepts/responses, a negedge monitor checks them.
module tb_sram_request_arbiter;

    logic        clock;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    typedef struct {
        logic        port;
        logic [31:0] val;
    } exp_t;

    exp_t acc_q[$];
    exp_t rsp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    sram_request_arbiter #(
        .MAX_OUTSTANDING(2),
        .STARVE_LIMIT   (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .inst_req    (inst_req),
        .inst_wr     (inst_wr),
        .inst_size   (inst_size),
        .inst_addr   (inst_addr),
        .inst_wdata  (inst_wdata),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_size   (data_size),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata  (data_rdata),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_size    (mem_size),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic [31:0] da, input logic aok, input logic dok,
                         input logic [31:0] rd);
        inst_req    = ir;
        inst_addr   = ia;
        data_req    = dr;
        data_addr   = da;
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = rd;
    endtask

    task automatic exp_acc(input logic port, input logic [31:0] addr);
        exp_t e;
        e.port = port;
        e.val  = addr;
        acc_q.push_back(e);
    endtask

    task automatic exp_rsp(input logic port, input logic [31:0] rd);
        exp_t e;
        e.port = port;
        e.val  = rd;
        rsp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every accept/response the DUT presents must match the head of its queue.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (inst_addr_ok || data_addr_ok) begin
                check("single_accept", 32'(inst_addr_ok && data_addr_ok), 32'd0);
                if (acc_q.size() == 0) begin
                    check("unexpected_accept", 32'(data_addr_ok), 32'hdead);
                end else begin
                    e = acc_q.pop_front();
                    check("accept_port", 32'(data_addr_ok), 32'(e.port));
                    check("accept_addr", mem_addr, e.val);
                end
            end
            if (inst_data_ok || data_data_ok) begin
                check("single_resp", 32'(inst_data_ok && data_data_ok), 32'd0);
                if (rsp_q.size() == 0) begin
                    check("unexpected_resp", 32'(data_data_ok), 32'hdead);
                end else begin
                    e = rsp_q.pop_front();
                    check("resp_port", 32'(data_data_ok), 32'(e.port));
                    check("resp_rdata", data_data_ok ? data_rdata : inst_rdata, e.val);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        inst_wr    = 1'b0;
        inst_size  = 2'd2;
        inst_wdata = 32'd0;
        data_wr    = 1'b0;
        data_size  = 2'd2;
        data_wdata = 32'h1234_5678;

        // Reset with every input active: nothing may be presented.
        reset = 1'b1;
        drive(1'b1, 32'hbfc0_0000, 1'b1, 32'h2000, 1'b1, 1'b1, 32'h5555);
        @(negedge clock);
        check("reset_mem_req", 32'(mem_req), 32'd0);
        check("reset_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        check("reset_data_addr_ok", 32'(data_addr_ok), 32'd0);
        check("reset_data_ok", 32'(inst_data_ok | data_data_ok), 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(negedge clock);
        check("idle_mem_req", 32'(mem_req), 32'd0);
        next_cycle();

        // Single instruction fetch, response next cycle.
        drive(1'b1, 32'hbfc0_0000, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        exp_acc(1'b0, 32'hbfc0_0000);
        @(negedge clock);
        check("fetch_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        next_cycle();
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h3c08_0001);
        exp_rsp(1'b0, 32'h3c08_0001);
        @(negedge clock);
        check("fetch_inst_data_ok", 32'(inst_data_ok), 32'd1);
        next_cycle();

        // Both request: data first, responses in order.
        drive(1'b1, 32'h1000, 1'b1, 32'h2000, 1'b1, 1'b0, 32'd0);
        exp_acc(1'b1, 32'h2000);
        @(negedge clock);
        check("both_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        next_cycle();
        drive(1'b1, 32'h1000, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        exp_acc(1'b0, 32'h1000);
        next_cycle();
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'haaaa);
        exp_rsp(1'b1, 32'haaaa);
        next_cycle();
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hbbbb);
        exp_rsp(1'b0, 32'hbbbb);
        next_cycle();

        // Lock holds instruction while the memory stalls, even once data requests.
        drive(1'b1, 32'h3000, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(negedge clock);
        check("lock_addr_c0", mem_addr, 32'h3000);
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h3000, 1'b1, 32'h4000, 1'b0, 1'b0, 32'd0);
            @(negedge clock);
            check("lock_addr_held", mem_addr, 32'h3000);
            next_cycle();
        end
        drive(1'b1, 32'h3000, 1'b1, 32'h4000, 1'b1, 1'b0, 32'd0);
        exp_acc(1'b0, 32'h3000);
        next_cycle();
        drive(1'b0, 32'd0, 1'b1, 32'h4000, 1'b1, 1'b0, 32'd0);
        exp_acc(1'b1, 32'h4000);
        next_cycle();
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h11);
        exp_rsp(1'b0, 32'h11);
        next_cycle();
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h22);
        exp_rsp(1'b1, 32'h22);
        next_cycle();

        // Starvation: four data wins, instruction forced through on the fifth.
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 32'h5000, 1'b1, 32'h6000, 1'b1, k > 1, 32'h100 + 32'(k));
            if (k == 5) exp_acc(1'b0, 32'h5000);
            else        exp_acc(1'b1, 32'h6000);
            if (k > 1) exp_rsp(1'b1, 32'h100 + 32'(k));
            @(negedge clock);
            check("starve_inst_addr_ok", 32'(inst_addr_ok), (k == 5) ? 32'd1 : 32'd0);
            next_cycle();
        end
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h106);
        exp_rsp(1'b0, 32'h106);
        next_cycle();

        // Full queue blocks mem_req; a same-cycle pop does not unblock it.
        drive(1'b1, 32'h7000, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        exp_acc(1'b0, 32'h7000);
        next_cycle();
        drive(1'b0, 32'd0, 1'b1, 32'h8000, 1'b1, 1'b0, 32'd0);
        exp_acc(1'b1, 32'h8000);
        next_cycle();
        drive(1'b0, 32'd0, 1'b1, 32'h9000, 1'b1, 1'b0, 32'd0);
        @(negedge clock);
        check("full_mem_req", 32'(mem_req), 32'd0);
        next_cycle();
        drive(1'b0, 32'd0, 1'b1, 32'h9000, 1'b1, 1'b1, 32'h77);
        exp_rsp(1'b0, 32'h77);
        @(negedge clock);
        check("full_pop_same_cycle", 32'(mem_req), 32'd0);
        next_cycle();
        drive(1'b0, 32'd0, 1'b1, 32'h9000, 1'b1, 1'b0, 32'd0);
        exp_acc(1'b1, 32'h9000);
        @(negedge clock);
        check("full_pop_next_cycle", 32'(mem_req), 32'd1);
        next_cycle();

        // Reset with two outstanding; late responses must be ignored.
        reset = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h88);
        @(negedge clock);
        check("midreset_data_ok", 32'(inst_data_ok | data_data_ok), 32'd0);
        next_cycle();
        reset = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h99);
        @(negedge clock);
        check("postreset_inst_data_ok", 32'(inst_data_ok), 32'd0);
        check("postreset_data_data_ok", 32'(data_data_ok), 32'd0);
        next_cycle();
        // Two back-to-back accepts only fit if the queue really is empty.
        drive(1'b1, 32'ha000, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        exp_acc(1'b0, 32'ha000);
        next_cycle();
        drive(1'b0, 32'd0, 1'b1, 32'hb000, 1'b1, 1'b0, 32'd0);
        exp_acc(1'b1, 32'hb000);
        @(negedge clock);
        check("postreset_second_accept", 32'(data_addr_ok), 32'd1);
        next_cycle();
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hc1);
        exp_rsp(1'b0, 32'hc1);
        next_cycle();
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hc2);
        exp_rsp(1'b1, 32'hc2);
        next_cycle();
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        next_cycle();
        next_cycle();

        check("accepts_left", 32'(acc_q.size()), 32'd0);
        check("responses_left", 32'(rsp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
